// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//
// Main control FSM for the multicycle MIPS datapath. Sequences the shared ALU,
// memory port, register file and immediate extender through the fetch, decode,
// execute, memory and writeback phases of each instruction.
//
// Optional feature macro: ZERO_EXT_IMM_EN
//   defined   -> ANDI/ORI decode to LOGIEX (zero-extended logic immediate)
//   undefined -> LOGIEX absent, ext_zero held 0, ANDI/ORI are illegal opcodes
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   op[5:0]           opcode from instruction register
//   zero              ALU zero flag (affects pc_en in BRANCH only)
//   mem_ready         memory handshake, access completes when 1
//   pc_en             PC write enable = pc_write | (branch & zero)
//   iord              memory address select: 0=PC, 1=ALUOut
//   mem_write         memory write strobe
//   mem_req           memory access request
//   ir_write          instruction register load
//   reg_dst           write register: 0=rt, 1=rd
//   mem_to_reg        writeback data: 0=ALUOut, 1=MDR
//   reg_write         register file write enable
//   alu_src_a         ALU A: 0=PC, 1=rs
//   alu_src_b[1:0]    ALU B: 00=rt, 01=4, 10=imm, 11=imm<<2
//   alu_op[1:0]       00=add, 01=sub, 10=funct, 11=logic-imm
//   pc_src[1:0]       00=ALU result, 01=ALUOut, 10=jump target
//   ext_zero          extender mode: 0=sign, 1=zero
//   illegal_op        one-cycle pulse on unknown opcode
//   instr_done        one-cycle pulse in final state of each instruction
//   state[3:0]        current state code (debug)

module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       mem_req,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       ext_zero,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef ZERO_EXT_IMM_EN
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
`ifdef ZERO_EXT_IMM_EN
        JUMP   = 4'd11,
        LOGIEX = 4'd12
`else
        JUMP   = 4'd11
`endif
    } state_t;

    state_t state_q, state_d;
    logic   pc_write;
    logic   branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        mem_req    = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        ext_zero   = 1'b0;
        illegal_op = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                // IR load and PC+4 update only commit once memory returns data
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
`ifdef ZERO_EXT_IMM_EN
                    OP_ANDI, OP_ORI: state_d = LOGIEX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`ifdef ZERO_EXT_IMM_EN
            LOGIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                ext_zero  = 1'b1;
                state_d   = ADDIWB;
            end
`endif
            // Unused codes recover to FETCH
            default: state_d = FETCH;
        endcase
    end

    assign pc_en = pc_write | (branch & zero);
    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//
// Self-checking bench for mips_multicycle_ctrl. Each test task queues a table
// of per-cycle stimulus steps with hand-written expected output vectors; the
// expectation is pushed to a scoreboard as the step is driven and popped and
// compared against the sampled DUT outputs shortly after.

module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_write, mem_req, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       ext_zero, illegal_op, instr_done;
    logic [3:0] state;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_write  (mem_write),
        .mem_req    (mem_req),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .ext_zero   (ext_zero),
        .illegal_op (illegal_op),
        .instr_done (instr_done),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] JMP   = 6'b000010;
    localparam logic [5:0] ANDI  = 6'b001100;
    localparam logic [5:0] ORI   = 6'b001101;
    localparam logic [5:0] BAD   = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic       ir_write;
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ext_zero;
        logic       illegal_op;
        logic       instr_done;
    } obs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       mr;
        logic       z;
        obs_t       exp;
    } step_t;

    localparam obs_t E_FETCH_STALL = '{st:4'd0, mem_req:1'b1, alu_src_b:2'b01, default:'0};
    localparam obs_t E_FETCH_RDY   = '{st:4'd0, mem_req:1'b1, alu_src_b:2'b01, pc_en:1'b1, ir_write:1'b1, default:'0};
    localparam obs_t E_DECODE      = '{st:4'd1, alu_src_b:2'b11, default:'0};
    localparam obs_t E_DECODE_ILL  = '{st:4'd1, alu_src_b:2'b11, illegal_op:1'b1, default:'0};
    localparam obs_t E_MEMADR      = '{st:4'd2, alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
    localparam obs_t E_MEMRD       = '{st:4'd3, mem_req:1'b1, iord:1'b1, default:'0};
    localparam obs_t E_MEMWB       = '{st:4'd4, mem_to_reg:1'b1, reg_write:1'b1, instr_done:1'b1, default:'0};
    localparam obs_t E_MEMWR_STALL = '{st:4'd5, mem_req:1'b1, iord:1'b1, mem_write:1'b1, default:'0};
    localparam obs_t E_MEMWR_RDY   = '{st:4'd5, mem_req:1'b1, iord:1'b1, mem_write:1'b1, instr_done:1'b1, default:'0};
    localparam obs_t E_EXEC        = '{st:4'd6, alu_src_a:1'b1, alu_op:2'b10, default:'0};
    localparam obs_t E_ALUWB       = '{st:4'd7, reg_dst:1'b1, reg_write:1'b1, instr_done:1'b1, default:'0};
    localparam obs_t E_BR_Z1       = '{st:4'd8, pc_en:1'b1, alu_src_a:1'b1, alu_op:2'b01, pc_src:2'b01, instr_done:1'b1, default:'0};
    localparam obs_t E_BR_Z0       = '{st:4'd8, alu_src_a:1'b1, alu_op:2'b01, pc_src:2'b01, instr_done:1'b1, default:'0};
    localparam obs_t E_ADDIEX      = '{st:4'd9, alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
    localparam obs_t E_ADDIWB      = '{st:4'd10, reg_write:1'b1, instr_done:1'b1, default:'0};
    localparam obs_t E_JUMP        = '{st:4'd11, pc_en:1'b1, pc_src:2'b10, instr_done:1'b1, default:'0};
    localparam obs_t E_LOGIEX      = '{st:4'd12, alu_src_a:1'b1, alu_src_b:2'b10, alu_op:2'b11, ext_zero:1'b1, default:'0};

    int    checks;
    int    failures;
    obs_t  sb[$];
    step_t stim[$];

    function automatic step_t mk(input logic r, input logic [5:0] o, input logic m,
                                 input logic z, input obs_t e);
        step_t s;
        s.rst = r; s.op = o; s.mr = m; s.z = z; s.exp = e;
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.pc_en = pc_en; o.ir_write = ir_write; o.mem_req = mem_req;
        o.mem_write = mem_write; o.iord = iord; o.reg_dst = reg_dst;
        o.mem_to_reg = mem_to_reg; o.reg_write = reg_write; o.alu_src_a = alu_src_a;
        o.alu_src_b = alu_src_b; o.alu_op = alu_op; o.pc_src = pc_src;
        o.ext_zero = ext_zero; o.illegal_op = illegal_op; o.instr_done = instr_done;
        return o;
    endfunction

    task automatic test_reset();
        step_t s; obs_t got, exp; int i;
        reset = 1'b1; op = LW; mem_ready = 1'b0; zero = 1'b0;
        @(posedge clk);
        stim.push_back(mk(1'b1, LW, 1'b0, 1'b0, E_FETCH_STALL));
        stim.push_back(mk(1'b1, LW, 1'b0, 1'b0, E_FETCH_STALL));
        i = 0;
        while (stim.size() > 0) begin
            s = stim.pop_front();
            @(negedge clk);
            reset = s.rst; op = s.op; mem_ready = s.mr; zero = s.z;
            sb.push_back(s.exp);
            #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset step %0d: got=%h expected=%h", i, got, exp);
            end
            i++;
        end
    endtask

    task automatic test_lw();
        step_t s; obs_t got, exp; int i;
        // zero held high outside BRANCH must not disturb anything
        stim.push_back(mk(1'b0, LW, 1'b1, 1'b1, E_FETCH_RDY));
        stim.push_back(mk(1'b0, LW, 1'b1, 1'b1, E_DECODE));
        stim.push_back(mk(1'b0, LW, 1'b1, 1'b1, E_MEMADR));
        stim.push_back(mk(1'b0, LW, 1'b1, 1'b1, E_MEMRD));
        stim.push_back(mk(1'b0, LW, 1'b1, 1'b1, E_MEMWB));
        stim.push_back(mk(1'b0, LW, 1'b0, 1'b1, E_FETCH_STALL));
        i = 0;
        while (stim.size() > 0) begin
            s = stim.pop_front();
            @(negedge clk);
            reset = s.rst; op = s.op; mem_ready = s.mr; zero = s.z;
            sb.push_back(s.exp);
            #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL lw step %0d: got=%h expected=%h", i, got, exp);
            end
            i++;
        end
    endtask

    task automatic test_beq();
        step_t s; obs_t got, exp; int i;
        stim.push_back(mk(1'b0, BEQ, 1'b1, 1'b1, E_FETCH_RDY));
        stim.push_back(mk(1'b0, BEQ, 1'b1, 1'b1, E_DECODE));
        stim.push_back(mk(1'b0, BEQ, 1'b1, 1'b1, E_BR_Z1));
        stim.push_back(mk(1'b0, BEQ, 1'b1, 1'b0, E_FETCH_RDY));
        stim.push_back(mk(1'b0, BEQ, 1'b1, 1'b0, E_DECODE));
        stim.push_back(mk(1'b0, BEQ, 1'b1, 1'b0, E_BR_Z0));
        stim.push_back(mk(1'b0, BEQ, 1'b0, 1'b1, E_FETCH_STALL));
        i = 0;
        while (stim.size() > 0) begin
            s = stim.pop_front();
            @(negedge clk);
            reset = s.rst; op = s.op; mem_ready = s.mr; zero = s.z;
            sb.push_back(s.exp);
            #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL beq step %0d: got=%h expected=%h", i, got, exp);
            end
            i++;
        end
    endtask

    task automatic test_fetch_stall();
        step_t s; obs_t got, exp; int i;
        for (int k = 0; k < 3; k++)
            stim.push_back(mk(1'b0, RTYPE, 1'b0, 1'b0, E_FETCH_STALL));
        stim.push_back(mk(1'b0, RTYPE, 1'b1, 1'b0, E_FETCH_RDY));
        // mem_ready low outside memory states must not stall
        stim.push_back(mk(1'b0, RTYPE, 1'b0, 1'b0, E_DECODE));
        stim.push_back(mk(1'b0, RTYPE, 1'b0, 1'b1, E_EXEC));
        stim.push_back(mk(1'b0, RTYPE, 1'b0, 1'b1, E_ALUWB));
        stim.push_back(mk(1'b0, RTYPE, 1'b0, 1'b0, E_FETCH_STALL));
        i = 0;
        while (stim.size() > 0) begin
            s = stim.pop_front();
            @(negedge clk);
            reset = s.rst; op = s.op; mem_ready = s.mr; zero = s.z;
            sb.push_back(s.exp);
            #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL fetch_stall step %0d: got=%h expected=%h", i, got, exp);
            end
            i++;
        end
    endtask

    task automatic test_sw();
        step_t s; obs_t got, exp; int i;
        stim.push_back(mk(1'b0, SW, 1'b1, 1'b0, E_FETCH_RDY));
        stim.push_back(mk(1'b0, SW, 1'b0, 1'b0, E_DECODE));
        stim.push_back(mk(1'b0, SW, 1'b0, 1'b0, E_MEMADR));
        stim.push_back(mk(1'b0, SW, 1'b0, 1'b0, E_MEMWR_STALL));
        stim.push_back(mk(1'b0, SW, 1'b0, 1'b0, E_MEMWR_STALL));
        stim.push_back(mk(1'b0, SW, 1'b1, 1'b0, E_MEMWR_RDY));
        stim.push_back(mk(1'b0, SW, 1'b0, 1'b0, E_FETCH_STALL));
        i = 0;
        while (stim.size() > 0) begin
            s = stim.pop_front();
            @(negedge clk);
            reset = s.rst; op = s.op; mem_ready = s.mr; zero = s.z;
            sb.push_back(s.exp);
            #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sw step %0d: got=%h expected=%h", i, got, exp);
            end
            i++;
        end
    endtask

    task automatic test_illegal();
        step_t s; obs_t got, exp; int i;
        stim.push_back(mk(1'b0, BAD, 1'b1, 1'b0, E_FETCH_RDY));
        stim.push_back(mk(1'b0, BAD, 1'b1, 1'b0, E_DECODE_ILL));
        stim.push_back(mk(1'b0, BAD, 1'b0, 1'b0, E_FETCH_STALL));
`ifdef ZERO_EXT_IMM_EN
        stim.push_back(mk(1'b0, ANDI, 1'b1, 1'b0, E_FETCH_RDY));
        stim.push_back(mk(1'b0, ANDI, 1'b1, 1'b0, E_DECODE));
        stim.push_back(mk(1'b0, ANDI, 1'b1, 1'b0, E_LOGIEX));
        stim.push_back(mk(1'b0, ANDI, 1'b1, 1'b0, E_ADDIWB));
        stim.push_back(mk(1'b0, ORI, 1'b1, 1'b0, E_FETCH_RDY));
        stim.push_back(mk(1'b0, ORI, 1'b1, 1'b0, E_DECODE));
        stim.push_back(mk(1'b0, ORI, 1'b1, 1'b0, E_LOGIEX));
        stim.push_back(mk(1'b0, ORI, 1'b1, 1'b0, E_ADDIWB));
`else
        stim.push_back(mk(1'b0, ANDI, 1'b1, 1'b0, E_FETCH_RDY));
        stim.push_back(mk(1'b0, ANDI, 1'b1, 1'b0, E_DECODE_ILL));
        stim.push_back(mk(1'b0, ORI, 1'b1, 1'b0, E_FETCH_RDY));
        stim.push_back(mk(1'b0, ORI, 1'b1, 1'b0, E_DECODE_ILL));
`endif
        stim.push_back(mk(1'b0, ORI, 1'b0, 1'b0, E_FETCH_STALL));
        i = 0;
        while (stim.size() > 0) begin
            s = stim.pop_front();
            @(negedge clk);
            reset = s.rst; op = s.op; mem_ready = s.mr; zero = s.z;
            sb.push_back(s.exp);
            #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL illegal step %0d: got=%h expected=%h", i, got, exp);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s; obs_t got, exp; int i;
        stim.push_back(mk(1'b0, ADDI, 1'b1, 1'b0, E_FETCH_RDY));
        stim.push_back(mk(1'b0, ADDI, 1'b1, 1'b0, E_DECODE));
        stim.push_back(mk(1'b0, ADDI, 1'b1, 1'b1, E_ADDIEX));
        stim.push_back(mk(1'b0, ADDI, 1'b1, 1'b0, E_ADDIWB));
        stim.push_back(mk(1'b0, JMP,  1'b1, 1'b0, E_FETCH_RDY));
        stim.push_back(mk(1'b0, JMP,  1'b1, 1'b0, E_DECODE));
        stim.push_back(mk(1'b0, JMP,  1'b1, 1'b0, E_JUMP));
        stim.push_back(mk(1'b0, JMP,  1'b0, 1'b0, E_FETCH_STALL));
        i = 0;
        while (stim.size() > 0) begin
            s = stim.pop_front();
            @(negedge clk);
            reset = s.rst; op = s.op; mem_ready = s.mr; zero = s.z;
            sb.push_back(s.exp);
            #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back step %0d: got=%h expected=%h", i, got, exp);
            end
            i++;
        end
    endtask

    task automatic test_reset_in_memrd();
        step_t s; obs_t got, exp; int i;
        stim.push_back(mk(1'b0, LW, 1'b1, 1'b0, E_FETCH_RDY));
        stim.push_back(mk(1'b0, LW, 1'b0, 1'b0, E_DECODE));
        stim.push_back(mk(1'b0, LW, 1'b0, 1'b0, E_MEMADR));
        stim.push_back(mk(1'b0, LW, 1'b0, 1'b0, E_MEMRD));
        stim.push_back(mk(1'b0, LW, 1'b0, 1'b0, E_MEMRD));
        // reset is synchronous: state still MEMRD until the next edge
        stim.push_back(mk(1'b1, LW, 1'b0, 1'b0, E_MEMRD));
        stim.push_back(mk(1'b0, LW, 1'b0, 1'b0, E_FETCH_STALL));
        i = 0;
        while (stim.size() > 0) begin
            s = stim.pop_front();
            @(negedge clk);
            reset = s.rst; op = s.op; mem_ready = s.mr; zero = s.z;
            sb.push_back(s.exp);
            #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_memrd step %0d: got=%h expected=%h", i, got, exp);
            end
            i++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_lw();
        test_beq();
        test_fetch_stall();
        test_sw();
        test_illegal();
        test_back_to_back();
        test_reset_in_memrd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
